// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants and code type for the OCI DCT trace packer.
// The packer top optionally adds drop accounting under NIOS2_OCI_DCT_DROP_CNT_EN.
package nios2_oci_dct_pkg;

  localparam int CODE_W = 2;
  localparam int SLOTS  = 15;
  localparam int CNT_W  = 4;
  localparam int BUF_W  = SLOTS * CODE_W;
  localparam int DROP_W = 8;

  typedef logic [CODE_W-1:0] dct_code_t;

  localparam dct_code_t DCT_NONE = 2'b00;
  localparam dct_code_t DCT_NT   = 2'b01;
  localparam dct_code_t DCT_TK   = 2'b10;
  localparam dct_code_t DCT_EXC  = 2'b11;

  function automatic logic is_code(input dct_code_t c);
    return c != DCT_NONE;
  endfunction

endpackage

// File: rtl/nios2_oci_dct_frame_reg.sv
// Single-entry valid/ready holding register for packed DCT frames.
// A load on the same edge as a handshake keeps the slot full (back-to-back).
module nios2_oci_dct_frame_reg #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);
  import nios2_oci_dct_pkg::*;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    valid_d = valid_q & !ready_i;
    data_d  = data_q;
    count_d = count_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      count_d = count_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit DCT codes into 15-slot frames and drives the stop handshake.
// NIOS2_OCI_DCT_DROP_CNT_EN adds a saturating count of rejected codes.
module nios2_oci_dct_packer #(
  parameter int SLOTS  = nios2_oci_dct_pkg::SLOTS,
  parameter int CODE_W = nios2_oci_dct_pkg::CODE_W,
  parameter int CNT_W  = nios2_oci_dct_pkg::CNT_W
`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
  ,
  parameter int DROP_W = nios2_oci_dct_pkg::DROP_W
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     code_valid,
  input  logic [CODE_W-1:0]        code,
  output logic                     code_ready,
  input  logic                     flush,
  input  logic                     trc_stop,
  output logic                     frm_valid,
  input  logic                     frm_ready,
  output logic [SLOTS*CODE_W-1:0]  frm_data,
  output logic [CNT_W-1:0]         frm_count,
  output logic [SLOTS*CODE_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic                     test_ending,
  output logic                     test_has_ended
`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]        drop_cnt
`endif
);
  import nios2_oci_dct_pkg::*;

  localparam int BUF_W = SLOTS * CODE_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

  logic [BUF_W-1:0] buf_q, buf_d, buf_n;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic             flush_pend_q, flush_pend_d, flush_pend_n;
  logic             stop_pend_q, stop_pend_d;
  logic             ended_q, ended_d;
  logic             accept, slot_free, xfer, ending;
  logic             frm_valid_w;

  assign code_ready = (cnt_q < FULL) & !stop_pend_q;
  assign accept     = code_valid & code_ready &
                      (code != CODE_W'(DCT_NONE));
  assign slot_free  = !frm_valid_w | frm_ready;

  always_comb begin
    buf_n = buf_q;
    cnt_n = cnt_q;
    if (accept) begin
      buf_n = {code, buf_q[BUF_W-1:CODE_W]};
      cnt_n = cnt_q + CNT_W'(1);
    end
    flush_pend_n = flush_pend_q | flush | trc_stop;
    xfer = slot_free &
           ((cnt_n == FULL) | (flush_pend_n & (cnt_n != '0)));
    // Stop completes only once accumulator and frame slot are both empty.
    ending = stop_pend_q & (cnt_q == '0) & !frm_valid_w;
    buf_d = xfer ? '0 : buf_n;
    cnt_d = xfer ? '0 : cnt_n;
    flush_pend_d = flush_pend_n & !xfer & (cnt_n != '0);
    stop_pend_d  = (stop_pend_q & !ending) | trc_stop;
    ended_d      = ended_q | ending;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      ended_q      <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      stop_pend_q  <= stop_pend_d;
      ended_q      <= ended_d;
    end
  end

  nios2_oci_dct_frame_reg #(
    .DATA_W (BUF_W),
    .CNT_W  (CNT_W)
  ) u_frame (
    .clk     (clk),
    .reset   (reset),
    .load_i  (xfer),
    .data_i  (buf_n),
    .count_i (cnt_n),
    .ready_i (frm_ready),
    .valid_o (frm_valid_w),
    .data_o  (frm_data),
    .count_o (frm_count)
  );

  assign frm_valid      = frm_valid_w;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_ending    = ending;
  assign test_has_ended = ended_q;

`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (code_valid & !code_ready &
        (code != CODE_W'(DCT_NONE)) & ~&drop_q)
      drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  // Rejected codes are simply not taken; nothing is counted.
`endif

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Scoreboard bench for nios2_oci_dct_packer with a queue-based model.
// Define NIOS2_OCI_DCT_DROP_CNT_EN to also check drop_cnt.
module tb_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cv = 1'b0;
  logic [1:0]  code = 2'b00;
  logic        fl = 1'b0;
  logic        st = 1'b0;
  logic        rdy = 1'b0;
  logic        code_ready, frm_valid, test_ending, test_has_ended;
  logic [29:0] frm_data, dct_buffer;
  logic [3:0]  frm_count, dct_count;
`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] d;
    int          n;
  } frm_t;

  frm_t exp_q[$];
  int   mq[$];
  bit   m_fv, m_fp, m_stop, m_has;
  logic [29:0] m_fd;
  int   m_fc;
  int   m_drop;

  always #5 clk = ~clk;

  nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset          (rst),
    .code_valid     (cv),
    .code           (code),
    .code_ready     (code_ready),
    .flush          (fl),
    .trc_stop       (st),
    .frm_valid      (frm_valid),
    .frm_ready      (rdy),
    .frm_data       (frm_data),
    .frm_count      (frm_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Codes listed oldest first; the newest lands in the top two bits.
  function automatic logic [29:0] pack(input int q[$]);
    logic [29:0] r;
    int n;
    r = '0;
    n = q.size();
    for (int i = 0; i < n; i++)
      r = r | (30'(q[i]) << (30 - 2 * (n - i)));
    return r;
  endfunction

  function automatic bit m_ready();
    return (mq.size() < 15) && !m_stop;
  endfunction

  function automatic bit m_end();
    return m_stop && (mq.size() == 0) && !m_fv;
  endfunction

  function automatic void check_outputs();
    chk("code_ready", 64'(code_ready), 64'(m_ready()));
    chk("dct_count", 64'(dct_count), 64'(mq.size()));
    chk("dct_buffer", 64'(dct_buffer), 64'(pack(mq)));
    chk("frm_valid", 64'(frm_valid), 64'(m_fv));
    chk("frm_data", 64'(frm_data), 64'(m_fd));
    chk("frm_count", 64'(frm_count), 64'(m_fc));
    chk("test_ending", 64'(test_ending), 64'(m_end()));
    chk("test_has_ended", 64'(test_has_ended), 64'(m_has));
`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
  endfunction

  function automatic void model_step();
    bit   r, e, acc, sf, pend;
    frm_t f;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_fv = 0; m_fp = 0; m_stop = 0; m_has = 0;
      m_fd = '0; m_fc = 0; m_drop = 0;
      return;
    end
    r = m_ready();
    e = m_end();
    acc = cv && r && (code != 2'b00);
    if (cv && !r && (code != 2'b00) && m_drop < 255) m_drop++;
    pend = m_fp || fl || st;
    if (acc) mq.push_back(int'(code));
    sf = !m_fv || rdy;
    if (m_fv && rdy) m_fv = 0;
    if (sf && (mq.size() == 15 || (pend && mq.size() > 0))) begin
      f.d = pack(mq);
      f.n = mq.size();
      exp_q.push_back(f);
      m_fd = f.d;
      m_fc = f.n;
      m_fv = 1;
      mq.delete();
      pend = 0;
    end
    if (mq.size() == 0) pend = 0;
    m_fp = pend;
    if (e) begin m_has = 1; m_stop = 0; end
    if (st) m_stop = 1;
  endfunction

  task automatic cycle();
    @(negedge clk);
    if (!rst) check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] c,
                       input bit f, input bit s, input bit r);
    cv = v; code = c; fl = f; st = s; rdy = r;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1; cv = 0; code = 0; fl = 0; st = 0; rdy = 0;
    cycle();
    cycle();
    rst = 0;
  endtask

  // Scoreboard monitor: pops one expected frame per handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && frm_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 64'(frm_count), 64'(0));
        end else begin
          frm_t e;
          e = exp_q.pop_front();
          chk("sb_data", 64'(frm_data), 64'(e.d));
          chk("sb_count", 64'(frm_count), 64'(e.n));
        end
      end
    end
  end

  initial begin
    do_reset();
    chk("reset_code_ready", 64'(code_ready), 64'(1));
    chk("reset_frm_valid", 64'(frm_valid), 64'(0));

    // Full frame of taken codes.
    for (int i = 0; i < 15; i++) drive(1, 2'b10, 0, 0, 1);
    chk("full_frm_data", 64'(frm_data), 64'(30'h2AAAAAAA));
    chk("full_frm_count", 64'(frm_count), 64'(15));
    for (int i = 0; i < 3; i++) drive(0, 2'b00, 0, 0, 1);

    // Partial flush, then flush of an empty accumulator.
    drive(1, 2'b01, 0, 0, 1);
    drive(1, 2'b10, 0, 0, 1);
    drive(1, 2'b11, 0, 0, 1);
    drive(0, 2'b00, 1, 0, 1);
    chk("flush_frm_data", 64'(frm_data), 64'(30'h39000000));
    chk("flush_frm_count", 64'(frm_count), 64'(3));
    for (int i = 0; i < 2; i++) drive(0, 2'b00, 0, 0, 1);
    drive(0, 2'b00, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 2'b00, 0, 0, 1);

    // Backpressure: 30 accepted, rest rejected, two frames on release.
    for (int i = 0; i < 40; i++) drive(1, 2'b01, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 2'b00, 0, 0, 1);

    // Code plus flush at occupancy 14 yields one full frame.
    for (int i = 0; i < 14; i++) drive(1, 2'b11, 0, 0, 1);
    drive(1, 2'b01, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 2'b00, 0, 0, 1);

    // Stop with a partial frame; codes blocked while stopping.
    for (int i = 0; i < 5; i++) drive(1, 2'b10, 0, 0, 0);
    drive(0, 2'b00, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 2'b10, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 2'b01, 0, 0, 1);
    chk("stop_has_ended", 64'(test_has_ended), 64'(1));
    do_reset();

    // Saturating drops, then reset mid-frame.
    for (int i = 0; i < 40; i++) drive(1, 2'b01, 0, 0, 0);
    for (int i = 0; i < 300; i++) drive(1, 2'b11, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) drive(1, 2'b10, 0, 0, 0);
    do_reset();
    drive(0, 2'b00, 0, 0, 0);
    chk("midreset_dct_count", 64'(dct_count), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0 ||
          (m_has && $urandom_range(0, 19) == 0)) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) != 0,
              2'($urandom_range(0, 3)),
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 249) == 0,
              $urandom_range(0, 2) != 0);
      end
    end

    // Drain everything still owed.
    drive(0, 2'b00, 1, 0, 1);
    for (int i = 0; i < 10; i++) drive(0, 2'b00, 0, 0, 1);
    chk("drain_exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
